// File: rtl/cla_addsub_pipe_if.sv
// Streaming port bundle for cla_addsub_pipe: operand side (in_*) and result side (out_*).
// With ADDSUB_SAT_EN defined, the operand beat also carries a per-beat saturate flag `sat`.
interface cla_addsub_pipe_if #(
  parameter int WIDTH = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             ci;
  logic             sub;
`ifdef ADDSUB_SAT_EN
  logic             sat;
`endif
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] s;
  logic             co;
  logic             ovf;
  logic             zero;

  modport master (
`ifdef ADDSUB_SAT_EN
    output sat,
`endif
    output in_valid, a, b, ci, sub, out_ready,
    input  in_ready, out_valid, s, co, ovf, zero
  );

  modport slave (
`ifdef ADDSUB_SAT_EN
    input  sat,
`endif
    input  in_valid, a, b, ci, sub, out_ready,
    output in_ready, out_valid, s, co, ovf, zero
  );
endinterface

// File: rtl/cla_addsub_pipe.sv
// Pipelined WIDTH-bit carry-lookahead adder/subtractor, one GRP-bit lookahead group resolved per stage.
// Optional ADDSUB_SAT_EN adds a per-beat saturation stage (latency NGRP+1 instead of NGRP).
module cla_addsub_pipe #(
  parameter int WIDTH = 16,
  parameter int GRP   = 4
) (
  input logic             clk,
  input logic             rst,
  cla_addsub_pipe_if.slave bus
);

  localparam int NGRP = WIDTH / GRP;

  generate
    if ((WIDTH % GRP) != 0) begin : g_bad_width
      $error("cla_addsub_pipe: WIDTH must be a multiple of GRP");
    end
  endgenerate

  // Full lookahead within one group: every carry is a flat sum of products of G/P terms and cin.
  function automatic logic [GRP:0] cla_group(input logic [GRP-1:0] x,
                                             input logic [GRP-1:0] y,
                                             input logic           cin);
    logic [GRP-1:0] g;
    logic [GRP-1:0] p;
    logic [GRP-1:0] sum;
    logic [GRP:0]   c;
    logic           acc;
    logic           prod;
    g    = x & y;
    p    = x | y;
    c    = '0;
    c[0] = cin;
    sum  = '0;
    for (int i = 0; i < GRP; i++) begin
      acc  = g[i];
      prod = p[i];
      for (int j = i - 1; j >= 0; j--) begin
        acc  = acc | (prod & g[j]);
        prod = prod & p[j];
      end
      c[i+1] = acc | (prod & cin);
    end
    for (int i = 0; i < GRP; i++) begin
      sum[i] = (p[i] & ~g[i]) ^ c[i];
    end
    return {c[GRP], sum};
  endfunction

  // Stage k carries full operands, the result bits of groups below k and the carry into group k.
  logic [WIDTH-1:0] a_pipe [NGRP];
  logic [WIDTH-1:0] b_pipe [NGRP];
  logic [WIDTH-1:0] s_pipe [NGRP];
  logic             c_pipe [NGRP];
  logic             v_pipe [NGRP];
  logic [GRP:0]     grp_res [NGRP];

  logic [WIDTH-1:0] b_eff;
  logic             c_eff;
  logic [WIDTH-1:0] fin_s;
  logic             fin_co;
  logic             fin_ovf;
  logic             stall;
  logic             adv;

  logic             out_valid_q;
  logic [WIDTH-1:0] s_q;
  logic             co_q;
  logic             ovf_q;
  logic             zero_q;

`ifdef ADDSUB_SAT_EN
  logic             sat_pipe [NGRP];
  logic             raw_valid;
  logic [WIDTH-1:0] raw_s;
  logic             raw_co;
  logic             raw_ovf;
  logic             raw_a_msb;
  logic             raw_sat;
  logic [WIDTH-1:0] sat_s;
`endif

  assign stall        = out_valid_q & ~bus.out_ready;
  assign adv          = ~stall;
  assign bus.in_ready = ~stall & ~rst;

  assign bus.out_valid = out_valid_q;
  assign bus.s         = s_q;
  assign bus.co        = co_q;
  assign bus.ovf       = ovf_q;
  assign bus.zero      = zero_q;

  assign b_eff = bus.sub ? ~bus.b : bus.b;
  assign c_eff = bus.sub ? 1'b1 : bus.ci;

  always_comb begin
    for (int k = 0; k < NGRP; k++) begin
      grp_res[k] = cla_group(a_pipe[k][k*GRP +: GRP], b_pipe[k][k*GRP +: GRP], c_pipe[k]);
    end
  end

  // Last group resolves straight into the result; overflow uses the effective (possibly inverted) B.
  always_comb begin
    fin_s                 = s_pipe[NGRP-1];
    fin_s[WIDTH-1 -: GRP] = grp_res[NGRP-1][GRP-1:0];
    fin_co                = grp_res[NGRP-1][GRP];
    fin_ovf               = (a_pipe[NGRP-1][WIDTH-1] == b_pipe[NGRP-1][WIDTH-1]) &
                            (fin_s[WIDTH-1] != a_pipe[NGRP-1][WIDTH-1]);
  end

`ifdef ADDSUB_SAT_EN
  always_comb begin
    sat_s = raw_s;
    if (raw_sat && raw_ovf) begin
      sat_s = raw_a_msb ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
    end
  end
`endif

  // One global enable: a stall freezes every stage, so bubbles hold their place.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < NGRP; k++) begin
        v_pipe[k] <= 1'b0;
      end
      out_valid_q <= 1'b0;
      s_q         <= '0;
      co_q        <= 1'b0;
      ovf_q       <= 1'b0;
      zero_q      <= 1'b0;
`ifdef ADDSUB_SAT_EN
      raw_valid   <= 1'b0;
`endif
    end else if (adv) begin
      v_pipe[0] <= bus.in_valid;
      a_pipe[0] <= bus.a;
      b_pipe[0] <= b_eff;
      c_pipe[0] <= c_eff;
      s_pipe[0] <= '0;
`ifdef ADDSUB_SAT_EN
      sat_pipe[0] <= bus.sat;
`endif
      for (int k = 1; k < NGRP; k++) begin
        v_pipe[k] <= v_pipe[k-1];
        a_pipe[k] <= a_pipe[k-1];
        b_pipe[k] <= b_pipe[k-1];
        c_pipe[k] <= grp_res[k-1][GRP];
        s_pipe[k] <= s_pipe[k-1];
        s_pipe[k][(k-1)*GRP +: GRP] <= grp_res[k-1][GRP-1:0];
`ifdef ADDSUB_SAT_EN
        sat_pipe[k] <= sat_pipe[k-1];
`endif
      end
`ifdef ADDSUB_SAT_EN
      raw_valid <= v_pipe[NGRP-1];
      if (v_pipe[NGRP-1]) begin
        raw_s     <= fin_s;
        raw_co    <= fin_co;
        raw_ovf   <= fin_ovf;
        raw_a_msb <= a_pipe[NGRP-1][WIDTH-1];
        raw_sat   <= sat_pipe[NGRP-1];
      end
      out_valid_q <= raw_valid;
      if (raw_valid) begin
        s_q    <= sat_s;
        co_q   <= raw_co;
        ovf_q  <= raw_ovf;
        zero_q <= (sat_s == '0);
      end
`else
      out_valid_q <= v_pipe[NGRP-1];
      if (v_pipe[NGRP-1]) begin
        s_q    <= fin_s;
        co_q   <= fin_co;
        ovf_q  <= fin_ovf;
        zero_q <= (fin_s == '0);
      end
`endif
    end
  end

endmodule

// File: tb/tb_cla_addsub_pipe.sv
// Directed-vector bench for cla_addsub_pipe (WIDTH=16, GRP=4); expected results are hand-computed.
// Also builds with ADDSUB_SAT_EN defined, where latency and saturated results change.
module tb_cla_addsub_pipe;

  localparam int WIDTH = 16;
  localparam int GRP   = 4;
`ifdef ADDSUB_SAT_EN
  localparam int LAT = 5;
`else
  localparam int LAT = 4;
`endif

  typedef struct packed {
    logic [15:0] s;
    logic        co;
    logic        ovf;
    logic        zero;
  } exp_t;

  logic  clk;
  logic  rst;
  int    num_checks;
  int    num_fail;
  exp_t  exp_q[$];
  exp_t  mon_exp;
  exp_t  held;

  logic [15:0] va [8];
  logic [15:0] vb [8];
  logic        vci [8];
  logic        vsub [8];
  exp_t        ve [8];

  cla_addsub_pipe_if #(.WIDTH(WIDTH)) bus ();

  cla_addsub_pipe #(.WIDTH(WIDTH), .GRP(GRP)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic exp_t mk(input logic [15:0] s, input logic co, input logic ovf, input logic zero);
    exp_t e;
    e.s    = s;
    e.co   = co;
    e.ovf  = ovf;
    e.zero = zero;
    return e;
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    num_checks++;
    if (observed !== expected) begin
      num_fail++;
      $display("[TB] FAIL %s: observed %0h expected %0h at %0t", tag, observed, expected, $time);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic setOperands(input logic [15:0] a, input logic [15:0] b, input logic ci, input logic sub);
    bus.a   = a;
    bus.b   = b;
    bus.ci  = ci;
    bus.sub = sub;
  endtask

  // Called just after a rising edge; returns just after the edge that accepted the beat.
  task automatic applyStimulus(input logic [15:0] a, input logic [15:0] b, input logic ci,
                               input logic sub, input exp_t e);
    int waited = 0;
    bus.in_valid = 1'b1;
    setOperands(a, b, ci, sub);
    #1;
    while (!bus.in_ready && waited < 50) begin
      tick();
      #1;
      waited++;
    end
    if (!bus.in_ready) begin
      checkOutput("accept_timeout", 32'd0, 32'd1);
      bus.in_valid = 1'b0;
    end else begin
      exp_q.push_back(e);
      tick();
      bus.in_valid = 1'b0;
    end
  endtask

  task automatic drain;
    int n = 0;
    while (exp_q.size() != 0 && n < 100) begin
      tick();
      n++;
    end
    checkOutput("drain", exp_q.size(), 32'd0);
    repeat (2) tick();
  endtask

  // Every completed output transfer is matched in order against the expected queue.
  always @(negedge clk) begin
    if (bus.out_valid && bus.out_ready) begin
      if (exp_q.size() == 0) begin
        checkOutput("unexpected_beat", 32'd1, 32'd0);
      end else begin
        mon_exp = exp_q.pop_front();
        checkOutput("s", bus.s, mon_exp.s);
        checkOutput("co", bus.co, mon_exp.co);
        checkOutput("ovf", bus.ovf, mon_exp.ovf);
        checkOutput("zero", bus.zero, mon_exp.zero);
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int idx;
    int cyc;
    num_checks = 0;
    num_fail   = 0;
    rst          = 1'b1;
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    setOperands(16'h0, 16'h0, 1'b0, 1'b0);
`ifdef ADDSUB_SAT_EN
    bus.sat = 1'b0;
`endif

    va[0] = 16'h0001; vb[0] = 16'h0002; vci[0] = 0; vsub[0] = 0; ve[0] = mk(16'h0003, 0, 0, 0);
    va[1] = 16'h00FF; vb[1] = 16'h0001; vci[1] = 0; vsub[1] = 0; ve[1] = mk(16'h0100, 0, 0, 0);
    va[2] = 16'h0F0F; vb[2] = 16'h00F1; vci[2] = 0; vsub[2] = 0; ve[2] = mk(16'h1000, 0, 0, 0);
    va[3] = 16'hABCD; vb[3] = 16'hABCD; vci[3] = 0; vsub[3] = 1; ve[3] = mk(16'h0000, 1, 0, 1);
    va[4] = 16'h8000; vb[4] = 16'h8000; vci[4] = 0; vsub[4] = 0; ve[4] = mk(16'h0000, 1, 1, 1);
    va[5] = 16'h1234; vb[5] = 16'h0234; vci[5] = 0; vsub[5] = 1; ve[5] = mk(16'h1000, 1, 0, 0);
    va[6] = 16'h0000; vb[6] = 16'h0001; vci[6] = 0; vsub[6] = 1; ve[6] = mk(16'hFFFF, 0, 0, 0);
    va[7] = 16'h5555; vb[7] = 16'hAAAA; vci[7] = 1; vsub[7] = 0; ve[7] = mk(16'h0000, 1, 0, 1);

    // Reset state
    repeat (2) tick();
    checkOutput("rst_out_valid", bus.out_valid, 32'd0);
    checkOutput("rst_s", bus.s, 32'd0);
    checkOutput("rst_co", bus.co, 32'd0);
    checkOutput("rst_ovf", bus.ovf, 32'd0);
    checkOutput("rst_zero", bus.zero, 32'd0);
    checkOutput("rst_in_ready", bus.in_ready, 32'd0);
    rst = 1'b0;
    tick();
    checkOutput("in_ready_idle", bus.in_ready, 32'd1);

    // Single beat and its latency
    applyStimulus(16'h1234, 16'h1111, 1'b1, 1'b0, mk(16'h2346, 0, 0, 0));
    for (int i = 0; i < LAT; i++) begin
      checkOutput("lat_early", bus.out_valid, 32'd0);
      tick();
    end
    checkOutput("lat_ontime", bus.out_valid, 32'd1);
    drain();

    // Full carry ripple, overflow corners and subtract cases
    applyStimulus(16'hFFFF, 16'h0001, 1'b0, 1'b0, mk(16'h0000, 1, 0, 1));
`ifdef ADDSUB_SAT_EN
    bus.sat = 1'b1;
    applyStimulus(16'h7FFF, 16'h0001, 1'b0, 1'b0, mk(16'h7FFF, 0, 1, 0));
    applyStimulus(16'h8000, 16'h0001, 1'b0, 1'b1, mk(16'h8000, 1, 1, 0));
    bus.sat = 1'b0;
`else
    applyStimulus(16'h7FFF, 16'h0001, 1'b0, 1'b0, mk(16'h8000, 0, 1, 0));
    applyStimulus(16'h8000, 16'h0001, 1'b0, 1'b1, mk(16'h7FFF, 1, 1, 0));
`endif
    applyStimulus(16'h0005, 16'h0007, 1'b0, 1'b1, mk(16'hFFFE, 0, 0, 0));
    applyStimulus(16'h1000, 16'h0001, 1'b1, 1'b1, mk(16'h0FFF, 1, 0, 0));
    drain();

    // Eight back-to-back beats with out_ready low for three cycles while results are pending
    idx = 0;
    cyc = 0;
    while (idx < 8 && cyc < 60) begin
      bus.in_valid  = 1'b1;
      setOperands(va[idx], vb[idx], vci[idx], vsub[idx]);
      bus.out_ready = !(cyc >= 6 && cyc <= 8);
      #1;
      if (cyc >= 6 && cyc <= 8) begin
        checkOutput("stall_in_ready", bus.in_ready, 32'd0);
        if (cyc == 6) begin
          held = {bus.s, bus.co, bus.ovf, bus.zero};
        end else begin
          checkOutput("stall_hold", {bus.s, bus.co, bus.ovf, bus.zero}, held);
          checkOutput("stall_valid", bus.out_valid, 32'd1);
        end
      end
      if (bus.in_ready) begin
        exp_q.push_back(ve[idx]);
        idx++;
      end
      tick();
      cyc++;
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    checkOutput("stream_sent", idx, 32'd8);
    drain();

    // Bubble between two beats must survive to the output
    bus.in_valid = 1'b1;
    setOperands(16'h0100, 16'h0200, 1'b0, 1'b0);
    exp_q.push_back(mk(16'h0300, 0, 0, 0));
    tick();
    bus.in_valid = 1'b0;
    tick();
    bus.in_valid = 1'b1;
    setOperands(16'h0003, 16'h0003, 1'b0, 1'b1);
    exp_q.push_back(mk(16'h0000, 1, 0, 1));
    tick();
    bus.in_valid = 1'b0;
    repeat (LAT - 2) tick();
    checkOutput("bubble_first", bus.out_valid, 32'd1);
    tick();
    checkOutput("bubble_gap", bus.out_valid, 32'd0);
    tick();
    checkOutput("bubble_second", bus.out_valid, 32'd1);
    drain();

    // Reset with a full pipe discards everything in flight
    for (int i = 0; i < 4; i++) begin
      bus.in_valid = 1'b1;
      setOperands(16'(i + 1), 16'(i + 1), 1'b0, 1'b0);
      tick();
    end
    bus.in_valid = 1'b0;
    rst = 1'b1;
    #1;
    checkOutput("midrst_in_ready", bus.in_ready, 32'd0);
    tick();
    checkOutput("midrst_out_valid", bus.out_valid, 32'd0);
    checkOutput("midrst_s", bus.s, 32'd0);
    rst = 1'b0;
    for (int i = 0; i < LAT + 3; i++) begin
      tick();
      checkOutput("no_stale", bus.out_valid, 32'd0);
    end

    checkOutput("queue_empty", exp_q.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", num_checks, num_fail);
    $finish;
  end

endmodule
